cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the instruction decoder/FSM in the multicycle ARMv4 core.
- Holds the NZCV flag register and evaluates the 4-bit condition field Instr[31:28] against the stored flags.
- Gates the decoder's raw write enables (PCS, RegW, MemW, FlagW) into architectural enables (PCWrite, RegWrite, MemWrite, flag update).
- Keeps saturating counters of executed and squashed instructions for debug and performance visibility.

Parameters:
- CNT_W, 16, width of the executed and squashed instruction counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- Cond  input  4  condition field Instr[31:28] from the instruction register
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  input  2  from decoder: [1] update N,Z; [0] update C,V
- PCS  input  1  from decoder: instruction writes PC (branch or Rd=15)
- NextPC  input  1  from FSM: unconditional PC increment (fetch)
- RegW  input  1  from FSM: raw register write enable
- MemW  input  1  from FSM: raw memory write enable
- IRWrite  input  1  from FSM: instruction register loaded this cycle
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register file write enable
- MemWrite  output  1  data memory write enable
- Flags  output  4  current stored {N,Z,C,V}
- CondExDelayed  output  1  latched condition result of the current instruction
- ExecCnt  output  CNT_W  instructions whose condition passed
- SquashCnt  output  CNT_W  instructions whose condition failed

Behaviour:
- Reset (reset=0, asynchronous): Flags=4'b0000, CondExDelayed=0, dec_cycle=0, ExecCnt=0, SquashCnt=0. Outputs stay at these values while reset is held. Reset mid-instruction abandons it with no pending writes.
- dec_cycle: an internal flop, equal to IRWrite delayed by one cycle. It is high exactly in the decode cycle, when Cond is valid.
- CondEx is combinational from Cond and the stored Flags (never ALUFlags):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (unpredictable in ARMv4; treated as never)
- CondExDelayed: loads CondEx on a clock edge where dec_cycle=1; holds otherwise. It stays stable for every later cycle of the instruction, including after a flag update.
- Counters: on that same edge, ExecCnt increments if CondEx=1, otherwise SquashCnt increments. Both saturate at all-ones and never wrap.
- Output gating, combinational, zero latency:
  - PCWrite = NextPC | (PCS & CondExDelayed)
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- Flag update: on a clock edge, if FlagW[1] & CondExDelayed then Flags[3:2] <= ALUFlags[3:2]; if FlagW[0] & CondExDelayed then Flags[1:0] <= ALUFlags[1:0]. Each half updates independently.
- Simultaneous flag update and dec_cycle=1: CondEx and the latch use pre-update Flags. The new flags become visible from the next cycle.
- NextPC is never gated, so fetch proceeds regardless of CondExDelayed, including immediately after reset.
- Squashed instructions: the FSM still sequences them, but RegWrite, MemWrite, branch PCWrite and the flag update are all held at 0.

Test Plan:
- Reset: hold reset=0 with RegW=MemW=PCS=1 and NextPC=0 -> PCWrite=RegWrite=MemWrite=0, Flags=0000, both counters 0. Release reset, pulse IRWrite with Cond=1110 -> ExecCnt=1 and CondExDelayed=1 one cycle after the decode cycle.
- Flag write: Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 on the next edge. Then Cond=0000 (EQ) decoded -> CondExDelayed=1, RegW=1 gives RegWrite=1.
- Squash: Flags=0100, Cond=0001 (NE), PCS=1, MemW=1, FlagW=11, ALUFlags=1011 -> PCWrite=0 (NextPC=0), MemWrite=0, Flags remains 0100, SquashCnt increments.
- Partial flag update: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100. Then FlagW=01, ALUFlags=0000 -> Flags=1100 unchanged... with ALUFlags=0011 -> Flags=1111.
- Signed conditions, with Flags N=1 Z=0 V=0:
  - Cond=1011 LT -> pass.
  - Cond=1100 GT -> fail.
  - Cond=1101 LE -> pass.
  - Cond=1111 -> fail with any flags.
- Saturation and async reset: CNT_W=4, 20 passing instructions -> ExecCnt=4'hF and holds. Assert reset=0 mid-cycle -> counters and Flags clear before the next clock edge.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution stage for the multicycle ARMv4 core: holds NZCV,
// evaluates the condition field, gates write enables and counts executed/squashed instructions.
module cond_unit #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondExDelayed,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic dec_cycle;
   logic cond_ex;
   logic flag_n, flag_z, flag_c, flag_v;

   assign {flag_n, flag_z, flag_c, flag_v} = Flags;

   // Condition evaluation always uses the stored flags, never the live ALU flags.
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Decode-cycle marker and the per-instruction condition latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_cycle     <= 1'b0;
         CondExDelayed <= 1'b0;
      end else begin
         dec_cycle <= IRWrite;
         if (dec_cycle) begin
            CondExDelayed <= cond_ex;
         end
      end
   end

   // Saturating executed / squashed counters, stepped once per decoded instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ExecCnt   <= '0;
         SquashCnt <= '0;
      end else if (dec_cycle) begin
         if (cond_ex) begin
            if (ExecCnt != CNT_MAX) begin
               ExecCnt <= ExecCnt + CNT_W'(1);
            end
         end else if (SquashCnt != CNT_MAX) begin
            SquashCnt <= SquashCnt + CNT_W'(1);
         end
      end
   end

   // N,Z and C,V halves update independently, only for instructions that passed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Flags <= 4'b0000;
      end else begin
         if (FlagW[1] && CondExDelayed) begin
            Flags[3:2] <= ALUFlags[3:2];
         end
         if (FlagW[0] && CondExDelayed) begin
            Flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   assign PCWrite  = NextPC | (PCS & CondExDelayed);
   assign RegWrite = RegW & CondExDelayed;
   assign MemWrite = MemW & CondExDelayed;

endmodule

// File: tb/tb_cond_unit.sv
// Directed, table-driven bench for cond_unit (counter width reduced to 4 to reach saturation).
module tb_cond_unit;

   localparam int unsigned CNT_W = 4;
   localparam int CNT_MAX = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, NextPC, RegW, MemW, IRWrite;
   logic             PCWrite, RegWrite, MemWrite;
   logic [3:0]       Flags;
   logic             CondExDelayed;
   logic [CNT_W-1:0] ExecCnt, SquashCnt;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
      .CondExDelayed(CondExDelayed), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] flags;
      logic [3:0] cond;
      logic       pass;
   } vec_t;

   vec_t vecs[23];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   exec_m = 0;
   int   squash_m = 0;
   logic [3:0] flags_m = 4'b0000;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
      PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; IRWrite = 1'b0;
   endtask

   // Fetch + decode one instruction; ALUFlags deliberately opposes stored flags.
   task automatic decode(input logic [3:0] c, input logic pass);
      idle_inputs();
      Cond = c;
      ALUFlags = ~flags_m;
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      tick();
      if (pass) begin
         if (exec_m < CNT_MAX) exec_m++;
      end else if (squash_m < CNT_MAX) squash_m++;
   endtask

   task automatic set_flags(input logic [3:0] f);
      decode(4'b1110, 1'b1);
      FlagW = 2'b11;
      ALUFlags = f;
      tick();
      FlagW = 2'b00;
      flags_m = f;
   endtask

   function automatic vec_t mk(input logic [3:0] f, input logic [3:0] c, input logic p);
      vec_t v;
      v.flags = f; v.cond = c; v.pass = p;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(4'b0100, 4'h0, 1'b1);
      vecs[1]  = mk(4'b0000, 4'h0, 1'b0);
      vecs[2]  = mk(4'b0100, 4'h1, 1'b0);
      vecs[3]  = mk(4'b0010, 4'h2, 1'b1);
      vecs[4]  = mk(4'b0010, 4'h3, 1'b0);
      vecs[5]  = mk(4'b1000, 4'h4, 1'b1);
      vecs[6]  = mk(4'b1000, 4'h5, 1'b0);
      vecs[7]  = mk(4'b0001, 4'h6, 1'b1);
      vecs[8]  = mk(4'b0001, 4'h7, 1'b0);
      vecs[9]  = mk(4'b0010, 4'h8, 1'b1);
      vecs[10] = mk(4'b0110, 4'h8, 1'b0);
      vecs[11] = mk(4'b0110, 4'h9, 1'b1);
      vecs[12] = mk(4'b0010, 4'h9, 1'b0);
      vecs[13] = mk(4'b1001, 4'hA, 1'b1);
      vecs[14] = mk(4'b1000, 4'hA, 1'b0);
      vecs[15] = mk(4'b1000, 4'hB, 1'b1);
      vecs[16] = mk(4'b1000, 4'hC, 1'b0);
      vecs[17] = mk(4'b0000, 4'hC, 1'b1);
      vecs[18] = mk(4'b1000, 4'hD, 1'b1);
      vecs[19] = mk(4'b0000, 4'hD, 1'b0);
      vecs[20] = mk(4'b0000, 4'hE, 1'b1);
      vecs[21] = mk(4'b1111, 4'hF, 1'b0);
      vecs[22] = mk(4'b0000, 4'hF, 1'b0);

      // Reset held with raw enables asserted.
      idle_inputs();
      reset = 1'b0;
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
      tick(); tick();
      chk("rst_pcwrite", 32'(PCWrite), 32'd0);
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chk("rst_flags", 32'(Flags), 32'd0);
      chk("rst_exec", 32'(ExecCnt), 32'd0);
      chk("rst_squash", 32'(SquashCnt), 32'd0);
      chk("rst_condex", 32'(CondExDelayed), 32'd0);
      NextPC = 1'b1;
      #1;
      chk("rst_nextpc", 32'(PCWrite), 32'd1);

      // First instruction after reset.
      idle_inputs();
      reset = 1'b1;
      tick();
      decode(4'b1110, 1'b1);
      chk("first_exec", 32'(ExecCnt), 32'd1);
      chk("first_condex", 32'(CondExDelayed), 32'd1);

      // Flag write, then EQ passes and drives writes.
      set_flags(4'b0100);
      chk("fw_flags", 32'(Flags), 32'h4);
      decode(4'h0, 1'b1);
      RegW = 1'b1; PCS = 1'b1;
      #1;
      chk("eq_regwrite", 32'(RegWrite), 32'd1);
      chk("eq_pcwrite", 32'(PCWrite), 32'd1);

      // Squashed NE: no writes, no flag change.
      decode(4'h1, 1'b0);
      PCS = 1'b1; MemW = 1'b1; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1011;
      #1;
      chk("sq_pcwrite", 32'(PCWrite), 32'd0);
      chk("sq_memwrite", 32'(MemWrite), 32'd0);
      chk("sq_regwrite", 32'(RegWrite), 32'd0);
      tick();
      chk("sq_flags", 32'(Flags), 32'h4);
      chk("sq_count", 32'(SquashCnt), 32'(squash_m));

      // Partial flag updates.
      set_flags(4'b0000);
      decode(4'hE, 1'b1);
      FlagW = 2'b10; ALUFlags = 4'b1111;
      tick();
      chk("pf_nz", 32'(Flags), 32'hC);
      FlagW = 2'b01; ALUFlags = 4'b0000;
      tick();
      chk("pf_cv0", 32'(Flags), 32'hC);
      ALUFlags = 4'b0011;
      tick();
      chk("pf_cv1", 32'(Flags), 32'hF);
      chk("pf_condex_hold", 32'(CondExDelayed), 32'd1);
      flags_m = 4'hF;

      // Flag update coinciding with the decode edge: latch sees old flags.
      set_flags(4'b0100);
      idle_inputs();
      Cond = 4'h0; IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      exec_m = (exec_m < CNT_MAX) ? exec_m + 1 : exec_m;
      flags_m = 4'b0000;
      chk("sim_flags", 32'(Flags), 32'h0);
      chk("sim_condex", 32'(CondExDelayed), 32'd1);
      FlagW = 2'b00;

      // Condition table.
      for (int i = 0; i < 23; i++) begin
         set_flags(vecs[i].flags);
         decode(vecs[i].cond, vecs[i].pass);
         chk($sformatf("cond_%0d", i), 32'(CondExDelayed), 32'(vecs[i].pass));
         chk($sformatf("cnt_%0d", i), {24'd0, ExecCnt, SquashCnt},
             32'((exec_m << 4) | squash_m));
      end

      // Saturation, then asynchronous reset between edges.
      set_flags(4'b1010);
      for (int i = 0; i < 20; i++) decode(4'hE, 1'b1);
      chk("sat_exec", 32'(ExecCnt), 32'hF);
      tick();
      chk("sat_hold", 32'(ExecCnt), 32'hF);
      chk("sat_flags", 32'(Flags), 32'hA);
      reset = 1'b0;
      #2;
      chk("arst_exec", 32'(ExecCnt), 32'd0);
      chk("arst_squash", 32'(SquashCnt), 32'd0);
      chk("arst_flags", 32'(Flags), 32'd0);
      chk("arst_condex", 32'(CondExDelayed), 32'd0);
      reset = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
